// File: rtl/ampel_defs.sv
// Shared traffic-light constants: car lamp codes, pedestrian lamp codes and
// the pedestrian request FSM state encoding.
package ampel_defs;

  localparam logic [2:0] RGB_RED    = 3'b100;
  localparam logic [2:0] RGB_YELLOW = 3'b110;
  localparam logic [2:0] RGB_GREEN  = 3'b010;

  localparam logic [1:0] PED_RED   = 2'b10;
  localparam logic [1:0] PED_GREEN = 2'b01;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    WAIT  = 3'd1,
    WALK  = 3'd2,
    FLASH = 3'd3,
    CLEAR = 3'd4
  } ped_state_e;

endpackage

// File: rtl/ped_request_if.sv
// Pedestrian-side signal bundle between the board button/LEDs, ctrl_ampel and
// the request unit.
interface ped_request_if;

  logic       BTN_RAW;
  logic [2:0] RGB;
  logic       BTN;
  logic [1:0] PED_RG;
  logic       WAIT_LED;

  modport master (
    input  BTN_RAW,
    input  RGB,
    output BTN,
    output PED_RG,
    output WAIT_LED
  );

  modport slave (
    output BTN_RAW,
    output RGB,
    input  BTN,
    input  PED_RG,
    input  WAIT_LED
  );

endinterface

// File: rtl/btn_debounce.sv
// Two-flop synchronizer plus counting debouncer; emits a registered one-cycle
// pulse when the debounced level rises.
module btn_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 32'd1000000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_raw,
  output logic press
);

  logic        sync1_q, sync2_q, level_q, press_q;
  logic [31:0] cnt_q;
  logic [31:0] cnt_inc;

  assign cnt_inc = cnt_q + 32'd1;
  assign press   = press_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      level_q <= 1'b0;
      press_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= btn_raw;
      sync2_q <= sync1_q;
      press_q <= 1'b0;
      if (sync2_q != level_q) begin
        if (cnt_inc == DEBOUNCE_CYCLES) begin
          level_q <= sync2_q;
          cnt_q   <= '0;
          press_q <= sync2_q;  // rising edges only
        end else begin
          cnt_q <= cnt_inc;
        end
      end else begin
        cnt_q <= '0;
      end
    end
  end

endmodule

// File: rtl/ped_request.sv
// Pedestrian request unit: raises BTN towards ctrl_ampel, detects the grant on
// car red and sequences the pedestrian lamp through walk, flash and clear.
module ped_request
  import ampel_defs::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 32'd1000000,
  parameter int unsigned WALK_CYCLES     = 32'd200000000,
  parameter int unsigned BLINK_CYCLES    = 32'd25000000
) (
  input logic           CLK,
  input logic           RES,
  ped_request_if.master bus
);

  ped_state_e  state_q;
  logic [31:0] walk_cnt_q, blink_cnt_q;
  logic [31:0] walk_inc, blink_inc;
  logic        blink_q, pending_q, btn_q, wait_led_q;
  logic [1:0]  ped_rg_q;
  logic        press, red, walk_done, blink_wrap, blink_next;

  btn_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_debounce (
    .clk    (CLK),
    .rst    (RES),
    .btn_raw(bus.BTN_RAW),
    .press  (press)
  );

  always_comb begin
    red        = (bus.RGB == RGB_RED);
    walk_inc   = walk_cnt_q + 32'd1;
    blink_inc  = blink_cnt_q + 32'd1;
    walk_done  = (walk_inc == WALK_CYCLES);
    blink_wrap = (blink_inc == BLINK_CYCLES);
    blink_next = blink_wrap ? ~blink_q : blink_q;
  end

  always_ff @(posedge CLK or posedge RES) begin
    if (RES) begin
      state_q     <= IDLE;
      walk_cnt_q  <= '0;
      blink_cnt_q <= '0;
      blink_q     <= 1'b0;
      pending_q   <= 1'b0;
      btn_q       <= 1'b0;
      wait_led_q  <= 1'b0;
      ped_rg_q    <= PED_RED;
    end else begin
      // Free-running blink; restarted in the "on" phase on entry to WAIT/FLASH.
      blink_cnt_q <= blink_wrap ? '0 : blink_inc;
      blink_q     <= blink_next;
      case (state_q)
        IDLE: begin
          btn_q      <= 1'b0;
          wait_led_q <= 1'b0;
          ped_rg_q   <= PED_RED;
          if (press) begin
            state_q     <= WAIT;
            btn_q       <= 1'b1;
            wait_led_q  <= 1'b1;
            blink_cnt_q <= '0;
            blink_q     <= 1'b1;
          end
        end
        WAIT: begin
          ped_rg_q <= PED_RED;
          if (red) begin
            state_q    <= WALK;
            btn_q      <= 1'b0;
            wait_led_q <= 1'b0;
            ped_rg_q   <= PED_GREEN;
            walk_cnt_q <= '0;
          end else begin
            btn_q      <= 1'b1;
            wait_led_q <= blink_next;
          end
        end
        WALK: begin
          walk_cnt_q <= walk_inc;
          if (!red) begin
            state_q  <= CLEAR;
            ped_rg_q <= PED_RED;
          end else if (walk_done) begin
            state_q     <= FLASH;
            ped_rg_q    <= PED_GREEN;
            blink_cnt_q <= '0;
            blink_q     <= 1'b1;
          end
        end
        FLASH: begin
          if (!red) begin
            state_q  <= CLEAR;
            ped_rg_q <= PED_RED;
          end else begin
            ped_rg_q <= {1'b0, blink_next};
          end
        end
        CLEAR: begin
          btn_q      <= 1'b0;
          wait_led_q <= 1'b0;
          ped_rg_q   <= PED_RED;
          if (red) begin
            pending_q <= 1'b0;
            // A press on the exit edge itself still counts as a request.
            if (pending_q || press) begin
              state_q     <= WAIT;
              btn_q       <= 1'b1;
              wait_led_q  <= 1'b1;
              blink_cnt_q <= '0;
              blink_q     <= 1'b1;
            end else begin
              state_q <= IDLE;
            end
          end else if (press) begin
            pending_q <= 1'b1;
          end
        end
        default: begin
          state_q    <= IDLE;
          btn_q      <= 1'b0;
          wait_led_q <= 1'b0;
          ped_rg_q   <= PED_RED;
          pending_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.BTN      = btn_q;
  assign bus.PED_RG   = ped_rg_q;
  assign bus.WAIT_LED = wait_led_q;

endmodule

// File: tb/tb_ped_request.sv
// Bench for ped_request: directed scenarios plus random stimulus, compared
// against a phase/elapsed-time model of the pedestrian request behaviour.
module tb_ped_request;
  import ampel_defs::*;

  localparam int D = 4;
  localparam int W = 6;
  localparam int B = 2;
  localparam int P_IDLE = 0, P_WAIT = 1, P_WALK = 2, P_FLASH = 3, P_CLEAR = 4;

  logic CLK = 1'b0;
  logic RES = 1'b0;
  int   errors = 0;
  int   checks = 0;

  // Model: phase, edges since phase entry, and the button conditioning state.
  int   m_ph, m_t, m_run;
  bit   m_s1, m_s2, m_lvl, m_evt, m_pend;

  logic [3:0] obs;
  logic [3:0] exp_v;

  ped_request_if bif ();

  ped_request #(
    .DEBOUNCE_CYCLES(D),
    .WALK_CYCLES    (W),
    .BLINK_CYCLES   (B)
  ) dut (
    .CLK(CLK),
    .RES(RES),
    .bus(bif.master)
  );

  always #5 CLK = ~CLK;

  assign obs = {bif.BTN, bif.PED_RG, bif.WAIT_LED};

  task automatic model_reset();
    m_ph = P_IDLE; m_t = 0; m_run = 0;
    m_s1 = 0; m_s2 = 0; m_lvl = 0; m_evt = 0; m_pend = 0;
  endtask

  task automatic model_enter(input int ph);
    m_ph = ph;
    m_t  = 0;
  endtask

  task automatic model_step();
    bit s, ev, red;
    s   = m_s2;
    ev  = m_evt;
    red = (bif.RGB == 3'b100);
    m_s2  = m_s1;
    m_s1  = bif.BTN_RAW;
    m_evt = 1'b0;
    if (s != m_lvl) begin
      m_run++;
      if (m_run == D) begin
        m_lvl = s; m_run = 0; m_evt = s;
      end
    end else begin
      m_run = 0;
    end
    m_t++;
    case (m_ph)
      P_IDLE:  if (ev) model_enter(P_WAIT);
      P_WAIT:  if (red) model_enter(P_WALK);
      P_WALK:  if (!red) model_enter(P_CLEAR); else if (m_t == W) model_enter(P_FLASH);
      P_FLASH: if (!red) model_enter(P_CLEAR);
      default: begin
        if (ev) m_pend = 1'b1;
        if (red) begin
          model_enter(m_pend ? P_WAIT : P_IDLE);
          m_pend = 1'b0;
        end
      end
    endcase
  endtask

  // {BTN, PED_RG, WAIT_LED}; blink is on for the first B edges of each 2B.
  function automatic logic [3:0] exp_out();
    logic bl;
    bl = ((m_t / B) % 2) == 0;
    case (m_ph)
      P_WAIT:  return {1'b1, 2'b10, bl};
      P_WALK:  return 4'b0010;
      P_FLASH: return {2'b00, bl, 1'b0};
      default: return 4'b0100;
    endcase
  endfunction

  task automatic tick();
    @(posedge CLK);
    model_step();
    @(negedge CLK);
  endtask

  // Pedestrian green must not survive a clock edge that saw a non-red car lamp.
  logic prev_nonred = 1'b0;
  initial forever begin
    @(negedge CLK);
    #2;
    if (RES) begin
      prev_nonred = 1'b0;
    end else begin
      checks++;
      if (prev_nonred && bif.PED_RG[0] === 1'b1) begin
        errors++;
        $display("FAIL safety_green ped_rg=%b rgb=%b required pedestrian not green", bif.PED_RG,
                 bif.RGB);
      end
      prev_nonred = (bif.RGB != 3'b100);
    end
  end

  task automatic test_reset();
    bif.BTN_RAW = 1'b0;
    bif.RGB     = RGB_RED;
    #2 RES = 1'b1;
    model_reset();
    #1;
    checks++;
    if (obs !== 4'b0100) begin
      errors++; $display("FAIL reset_async got=%b want=0100", obs);
    end
    @(negedge CLK);
    RES = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      checks++;
      if (obs !== 4'b0100 || obs !== exp_out()) begin
        errors++; $display("FAIL reset_idle cyc=%0d got=%b want=0100", i, obs);
      end
    end
  endtask

  task automatic test_bounce();
    for (int i = 0; i < 12; i++) begin
      bif.BTN_RAW = (i % 4) != 3;
      tick();
      checks++;
      if (obs !== exp_out() || bif.BTN !== 1'b0) begin
        errors++; $display("FAIL bounce_reject cyc=%0d got=%b want=%b", i, obs, exp_out());
      end
    end
    bif.BTN_RAW = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      tick();
      exp_v = (k < 7) ? 4'b0100 : (k == 7) ? 4'b1101 : 4'b0010;
      checks++;
      if (obs !== exp_v || obs !== exp_out()) begin
        errors++; $display("FAIL press_latency edge=%0d got=%b want=%b", k, obs, exp_v);
      end
    end
  endtask

  task automatic test_walk();
    logic bl;
    bif.BTN_RAW = 1'b0;
    for (int j = 1; j <= 13; j++) begin
      tick();
      bl    = (((j - 6) / 2) % 2) == 0;
      exp_v = (j < 6) ? 4'b0010 : {2'b00, bl, 1'b0};
      checks++;
      if (obs !== exp_v || obs !== exp_out()) begin
        errors++; $display("FAIL walk_seq cyc=%0d got=%b want=%b", j, obs, exp_v);
      end
    end
    bif.RGB = RGB_YELLOW;
    tick();
    checks++;
    if (obs !== 4'b0100 || obs !== exp_out()) begin
      errors++; $display("FAIL walk_red_drop got=%b want=0100", obs);
    end
    bif.RGB = RGB_RED;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (obs !== 4'b0100 || obs !== exp_out()) begin
        errors++; $display("FAIL walk_back_idle cyc=%0d got=%b want=0100", i, obs);
      end
    end
  endtask

  task automatic wait_for_btn(input string name);
    int n;
    n = 0;
    while (bif.BTN !== 1'b1 && n < 20) begin
      tick();
      n++;
      checks++;
      if (obs !== exp_out()) begin
        errors++; $display("FAIL %s_model cyc=%0d got=%b want=%b", name, n, obs, exp_out());
      end
    end
    checks++;
    if (bif.BTN !== 1'b1) begin
      errors++; $display("FAIL %s_timeout btn=%b want=1", name, bif.BTN);
    end
  endtask

  task automatic test_cars_flowing();
    bif.RGB     = RGB_GREEN;
    bif.BTN_RAW = 1'b1;
    wait_for_btn("cars_request");
    bif.BTN_RAW = 1'b0;
    for (int t = 0; t < 8; t++) begin
      if (t > 0) tick();
      exp_v = {1'b1, 2'b10, ((t / 2) % 2) == 0};
      checks++;
      if (obs !== exp_v || obs !== exp_out()) begin
        errors++; $display("FAIL cars_wait_led cyc=%0d got=%b want=%b", t, obs, exp_v);
      end
    end
    bif.RGB = RGB_RED;
    tick();
    checks++;
    if (obs !== 4'b0010 || obs !== exp_out()) begin
      errors++; $display("FAIL cars_grant got=%b want=0010", obs);
    end
    bif.RGB = RGB_YELLOW;
    tick();
    bif.RGB = RGB_RED;
    tick();
    tick();
    checks++;
    if (obs !== 4'b0100 || obs !== exp_out()) begin
      errors++; $display("FAIL cars_idle got=%b want=0100", obs);
    end
  endtask

  task automatic test_safety();
    // A press whose event lands in WALK must not raise a second request.
    bif.RGB     = RGB_GREEN;
    bif.BTN_RAW = 1'b1;
    wait_for_btn("safety_request");
    bif.BTN_RAW = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    bif.BTN_RAW = 1'b1;
    bif.RGB     = RGB_RED;
    for (int k = 1; k <= 10; k++) begin
      tick();
      checks++;
      if (bif.BTN !== 1'b0 || obs !== exp_out() || (k == 1 && obs !== 4'b0010)) begin
        errors++; $display("FAIL walk_press_ignored cyc=%0d got=%b want=%b", k, obs, exp_out());
      end
    end
    bif.RGB = RGB_YELLOW;
    tick();
    bif.RGB = RGB_RED;
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if (obs !== 4'b0100 || obs !== exp_out()) begin
        errors++; $display("FAIL walk_press_no_req cyc=%0d got=%b want=0100", i, obs);
      end
    end
    // Red drops early in WALK; a press during CLEAR is queued.
    bif.BTN_RAW = 1'b0;
    for (int i = 0; i < 8; i++) tick();
    bif.BTN_RAW = 1'b1;
    for (int n = 0; n < 12 && bif.PED_RG !== 2'b01; n++) tick();
    checks++;
    if (bif.PED_RG !== 2'b01 || obs !== exp_out()) begin
      errors++; $display("FAIL override_grant got=%b want=0010", obs);
    end
    bif.BTN_RAW = 1'b0;
    tick();
    tick();
    bif.RGB = RGB_YELLOW;
    tick();
    checks++;
    if (obs !== 4'b0100 || obs !== exp_out()) begin
      errors++; $display("FAIL override_red got=%b want=0100", obs);
    end
    for (int i = 0; i < 8; i++) tick();
    bif.BTN_RAW = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      checks++;
      if (obs !== 4'b0100 || obs !== exp_out()) begin
        errors++; $display("FAIL clear_hold cyc=%0d got=%b want=0100", i, obs);
      end
    end
    bif.RGB = RGB_RED;
    tick();
    checks++;
    if (obs !== 4'b1101 || obs !== exp_out()) begin
      errors++; $display("FAIL queued_request got=%b want=1101", obs);
    end
    tick();
    checks++;
    if (obs !== 4'b0010 || obs !== exp_out()) begin
      errors++; $display("FAIL queued_grant got=%b want=0010", obs);
    end
    bif.RGB = RGB_YELLOW;
    tick();
    bif.RGB = RGB_RED;
    tick();
    tick();
  endtask

  task automatic test_reset_mid_walk();
    bif.BTN_RAW = 1'b0;
    for (int i = 0; i < 8; i++) tick();
    bif.BTN_RAW = 1'b1;
    bif.RGB     = RGB_RED;
    for (int n = 0; n < 12 && bif.PED_RG !== 2'b01; n++) tick();
    tick();
    tick();
    checks++;
    if (obs !== 4'b0010 || obs !== exp_out()) begin
      errors++; $display("FAIL midwalk_setup got=%b want=0010", obs);
    end
    #2 RES = 1'b1;
    model_reset();
    #1;
    checks++;
    if (obs !== 4'b0100) begin
      errors++; $display("FAIL reset_mid_walk got=%b want=0100", obs);
    end
    @(negedge CLK);
    RES     = 1'b0;
    bif.RGB = RGB_GREEN;
    for (int k = 1; k <= 7; k++) begin
      tick();
      exp_v = (k == 7) ? 4'b1101 : 4'b0100;
      checks++;
      if (obs !== exp_v || obs !== exp_out()) begin
        errors++; $display("FAIL fresh_press edge=%0d got=%b want=%b", k, obs, exp_v);
      end
    end
    bif.RGB = RGB_RED;
    tick();
    checks++;
    if (obs !== 4'b0010 || obs !== exp_out()) begin
      errors++; $display("FAIL fresh_grant got=%b want=0010", obs);
    end
    bif.RGB = RGB_YELLOW;
    tick();
    bif.RGB = RGB_RED;
    tick();
    tick();
  endtask

  task automatic test_random();
    int hold;
    hold = 0;
    for (int i = 0; i < 400; i++) begin
      if (hold == 0) begin
        case ($urandom_range(0, 7))
          0, 1, 2, 3: bif.RGB = RGB_RED;
          4:          bif.RGB = RGB_YELLOW;
          5:          bif.RGB = RGB_GREEN;
          6:          bif.RGB = 3'b000;
          default:    bif.RGB = 3'b111;
        endcase
        hold = $urandom_range(1, 14);
      end
      hold--;
      if ($urandom_range(0, 7) == 0) bif.BTN_RAW = ~bif.BTN_RAW;
      tick();
      checks++;
      if (obs !== exp_out()) begin
        errors++; $display("FAIL random cyc=%0d rgb=%b got=%b want=%b", i, bif.RGB, obs, exp_out());
      end
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();
    test_reset();
    test_bounce();
    test_walk();
    test_cars_flowing();
    test_safety();
    test_reset_mid_walk();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
